// File: rtl/jtframe_vtimer_if.sv
// jtframe_vtimer_if
//   Video timing bundle between the timing generator and its consumers.
//   Signals:
//     pxl_cen    pixel clock enable (consumer -> timer)
//     H, V       9-bit horizontal / vertical counters
//     Hinit      high during the last pixel of a line
//     Vinit      high during the last pixel of a frame
//     LHBL/LVBL  active-low horizontal / vertical blanking
//     HS/VS      active-high horizontal / vertical sync
//     frame_cnt  8-bit frame counter (only with JTFRAME_VTIMER_FRAMECNT_EN)
//   Modports: master = timing generator, slave = consumer.
//   Optional macro: JTFRAME_VTIMER_FRAMECNT_EN adds frame_cnt.
interface jtframe_vtimer_if;
    logic       pxl_cen;
    logic [8:0] H;
    logic [8:0] V;
    logic       Hinit;
    logic       Vinit;
    logic       LHBL;
    logic       LVBL;
    logic       HS;
    logic       VS;
`ifdef JTFRAME_VTIMER_FRAMECNT_EN
    logic [7:0] frame_cnt;

    modport master (
        input  pxl_cen,
        output H, V, Hinit, Vinit, LHBL, LVBL, HS, VS, frame_cnt
    );
    modport slave (
        output pxl_cen,
        input  H, V, Hinit, Vinit, LHBL, LVBL, HS, VS, frame_cnt
    );
`else
    modport master (
        input  pxl_cen,
        output H, V, Hinit, Vinit, LHBL, LVBL, HS, VS
    );
    modport slave (
        output pxl_cen,
        input  H, V, Hinit, Vinit, LHBL, LVBL, HS, VS
    );
`endif
endinterface

// File: rtl/jtframe_vtimer.sv
// jtframe_vtimer
//   Horizontal/vertical video timing generator. H counts pixels within a
//   line, V counts lines within a frame; both advance only on pxl_cen.
//   Blanking and sync flags are registered from the next counter values so
//   they change on the same edge as H/V.
//   Ports:
//     clk   system clock
//     rst   synchronous active-high reset
//     vid   jtframe_vtimer_if.master (pxl_cen in; H, V, Hinit, Vinit,
//           LHBL, LVBL, HS, VS out; frame_cnt out when enabled)
//   Optional macro: JTFRAME_VTIMER_FRAMECNT_EN adds an 8-bit wrapping frame
//   counter that advances on the pixel where Vinit is high.
module jtframe_vtimer #(
    parameter logic [8:0] HCNT_START = 9'd0,
    parameter logic [8:0] HCNT_END   = 9'd383,
    parameter logic [8:0] HB_START   = 9'd255,
    parameter logic [8:0] HB_END     = 9'd383,
    parameter logic [8:0] HS_START   = 9'd330,
    parameter logic [8:0] HS_END     = 9'd356,
    parameter logic [8:0] V_START    = 9'd0,
    parameter logic [8:0] VCNT_END   = 9'd262,
    parameter logic [8:0] VB_START   = 9'd223,
    parameter logic [8:0] VB_END     = 9'd262,
    parameter logic [8:0] VS_START   = 9'd245,
    parameter logic [8:0] VS_END     = 9'd248
) (
    input  logic           clk,
    input  logic           rst,
    jtframe_vtimer_if.master vid
);

    logic [8:0] h_reg, h_next;
    logic [8:0] v_reg, v_next;
    logic       lhbl_reg, lhbl_next;
    logic       lvbl_reg, lvbl_next;
    logic       hs_reg, hs_next;
    logic       vs_reg, vs_next;
    logic       hinit;
    logic       vinit;

    assign hinit = (h_reg == HCNT_END);
    assign vinit = hinit && (v_reg == VCNT_END);

    // Next counter values; equal to the current ones when pxl_cen is low,
    // which lets the flag registers load unconditionally below.
    always_comb begin
        h_next = h_reg;
        v_next = v_reg;
        if (vid.pxl_cen) begin
            if (hinit) begin
                h_next = HCNT_START;
                v_next = (v_reg == VCNT_END) ? V_START : v_reg + 9'd1;
            end else begin
                h_next = h_reg + 9'd1;
            end
        end
    end

    // Flags decoded from the next counters so they line up with H/V.
    // V only moves at line wrap, so LVBL/VS only change there too.
    always_comb begin
        lhbl_next = !((h_next > HB_START) && (h_next <= HB_END));
        lvbl_next = !((v_next > VB_START) && (v_next <= VB_END));
        hs_next   = (h_next >= HS_START) && (h_next < HS_END);
        vs_next   = (v_next >= VS_START) && (v_next < VS_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_reg    <= HCNT_START;
            v_reg    <= V_START;
            lhbl_reg <= 1'b1;
            lvbl_reg <= 1'b1;
            hs_reg   <= 1'b0;
            vs_reg   <= 1'b0;
        end else begin
            h_reg    <= h_next;
            v_reg    <= v_next;
            lhbl_reg <= lhbl_next;
            lvbl_reg <= lvbl_next;
            hs_reg   <= hs_next;
            vs_reg   <= vs_next;
        end
    end

    assign vid.H     = h_reg;
    assign vid.V     = v_reg;
    assign vid.Hinit = hinit;
    assign vid.Vinit = vinit;
    assign vid.LHBL  = lhbl_reg;
    assign vid.LVBL  = lvbl_reg;
    assign vid.HS    = hs_reg;
    assign vid.VS    = vs_reg;

`ifdef JTFRAME_VTIMER_FRAMECNT_EN
    logic [7:0] frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_reg <= 8'd0;
        end else if (vid.pxl_cen && vinit) begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    assign vid.frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_jtframe_vtimer.sv
// tb_jtframe_vtimer
//   Directed bench. dut_a uses the full 384x263 geometry with a 320-pixel
//   visible line and 240 visible lines; dut_b uses a reduced 16x10 geometry
//   so whole frames (vertical flags, Vinit, frame wrap) fit in a short run.
//   dut_b: H 0..15, LHBL=0 for H 12..15, HS for H 12..13;
//          V 0..9,  LVBL=0 for V 7..9,   VS for V 7.
module tb_jtframe_vtimer;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic pxl_cen = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jtframe_vtimer_if bus_a ();
    jtframe_vtimer_if bus_b ();

    assign bus_a.pxl_cen = pxl_cen;
    assign bus_b.pxl_cen = pxl_cen;

    jtframe_vtimer #(
        .HB_START (9'd319),
        .VB_START (9'd239)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .vid (bus_a)
    );

    jtframe_vtimer #(
        .HCNT_START (9'd0),
        .HCNT_END   (9'd15),
        .HB_START   (9'd11),
        .HB_END     (9'd15),
        .HS_START   (9'd12),
        .HS_END     (9'd14),
        .V_START    (9'd0),
        .VCNT_END   (9'd9),
        .VB_START   (9'd6),
        .VB_END     (9'd9),
        .VS_START   (9'd7),
        .VS_END     (9'd8)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .vid (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clk edge with the given pxl_cen; returns 1 time unit after the edge.
    task automatic tick(input logic cen);
        @(negedge clk);
        pxl_cen = cen;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, " H"},    32'(bus_a.H), 0);
        chk({tag, " V"},    32'(bus_a.V), 0);
        chk({tag, " LHBL"}, 32'(bus_a.LHBL), 1);
        chk({tag, " LVBL"}, 32'(bus_a.LVBL), 1);
        chk({tag, " HS"},   32'(bus_a.HS), 0);
        chk({tag, " VS"},   32'(bus_a.VS), 0);
    endtask

    task automatic chk_reset_b(input string tag);
        chk({tag, " H"},    32'(bus_b.H), 0);
        chk({tag, " V"},    32'(bus_b.V), 0);
        chk({tag, " LHBL"}, 32'(bus_b.LHBL), 1);
        chk({tag, " LVBL"}, 32'(bus_b.LVBL), 1);
        chk({tag, " HS"},   32'(bus_b.HS), 0);
        chk({tag, " VS"},   32'(bus_b.VS), 0);
    endtask

    initial begin
        int eh;
        int ev;
        int vinit_cnt;

        // Reset held with pxl_cen high: counters must stay at the origin.
        tick(1'b1);
        tick(1'b1);
        chk_reset_a("a_reset");
        chk("a_reset Hinit", 32'(bus_a.Hinit), 0);
        chk("a_reset Vinit", 32'(bus_a.Vinit), 0);
        $display("txn reset: H=%0d V=%0d", bus_a.H, bus_a.V);

        // One full line: H 1..383 then 0, V 0 -> 1.
        rst_a = 1'b0;
        for (int k = 1; k <= 384; k++) begin
            tick(1'b1);
            eh = k % 384;
            ev = (k == 384) ? 1 : 0;
            chk($sformatf("a_line H k=%0d", k),     32'(bus_a.H), eh);
            chk($sformatf("a_line V k=%0d", k),     32'(bus_a.V), ev);
            chk($sformatf("a_line Hinit k=%0d", k), 32'(bus_a.Hinit), (eh == 383) ? 1 : 0);
            chk($sformatf("a_line Vinit k=%0d", k), 32'(bus_a.Vinit), 0);
            chk($sformatf("a_line LHBL k=%0d", k),  32'(bus_a.LHBL), (eh > 319) ? 0 : 1);
            chk($sformatf("a_line LVBL k=%0d", k),  32'(bus_a.LVBL), 1);
            chk($sformatf("a_line HS k=%0d", k),    32'(bus_a.HS), (eh >= 330 && eh <= 355) ? 1 : 0);
            chk($sformatf("a_line VS k=%0d", k),    32'(bus_a.VS), 0);
        end
        $display("txn line: after 384 pxl_cen H=%0d V=%0d", bus_a.H, bus_a.V);

        // Move into the sync/blank region of line 1 and freeze for 50 clks.
        for (int k = 0; k < 340; k++) tick(1'b1);
        chk("a_pre_freeze H", 32'(bus_a.H), 340);
        chk("a_pre_freeze V", 32'(bus_a.V), 1);
        for (int k = 0; k < 50; k++) begin
            tick(1'b0);
            chk($sformatf("a_freeze H c=%0d", k),     32'(bus_a.H), 340);
            chk($sformatf("a_freeze V c=%0d", k),     32'(bus_a.V), 1);
            chk($sformatf("a_freeze LHBL c=%0d", k),  32'(bus_a.LHBL), 0);
            chk($sformatf("a_freeze HS c=%0d", k),    32'(bus_a.HS), 1);
            chk($sformatf("a_freeze LVBL c=%0d", k),  32'(bus_a.LVBL), 1);
            chk($sformatf("a_freeze Hinit c=%0d", k), 32'(bus_a.Hinit), 0);
        end
        $display("txn freeze: 50 idle clks H=%0d V=%0d HS=%0d", bus_a.H, bus_a.V, bus_a.HS);

        // Reset mid-line with pxl_cen low, then one pxl_cen after release.
        rst_a = 1'b1;
        tick(1'b0);
        chk_reset_a("a_midrst");
        rst_a = 1'b0;
        tick(1'b1);
        chk("a_after_rst H", 32'(bus_a.H), 1);
        chk("a_after_rst V", 32'(bus_a.V), 0);
        $display("txn midline reset: first pxl_cen H=%0d V=%0d", bus_a.H, bus_a.V);

        // Small geometry: reset state then one full frame of 160 pxl_cen.
        chk_reset_b("b_reset");
`ifdef JTFRAME_VTIMER_FRAMECNT_EN
        chk("b_reset frame_cnt", 32'(bus_b.frame_cnt), 0);
`endif
        rst_b = 1'b0;
        vinit_cnt = 0;
        for (int k = 1; k <= 160; k++) begin
            tick(1'b1);
            eh = k % 16;
            ev = (k / 16) % 10;
            if (bus_b.Vinit === 1'b1) vinit_cnt++;
            chk($sformatf("b_frame H k=%0d", k),     32'(bus_b.H), eh);
            chk($sformatf("b_frame V k=%0d", k),     32'(bus_b.V), ev);
            chk($sformatf("b_frame Hinit k=%0d", k), 32'(bus_b.Hinit), (eh == 15) ? 1 : 0);
            chk($sformatf("b_frame Vinit k=%0d", k), 32'(bus_b.Vinit), (eh == 15 && ev == 9) ? 1 : 0);
            chk($sformatf("b_frame LHBL k=%0d", k),  32'(bus_b.LHBL), (eh >= 12) ? 0 : 1);
            chk($sformatf("b_frame HS k=%0d", k),    32'(bus_b.HS), (eh == 12 || eh == 13) ? 1 : 0);
            chk($sformatf("b_frame LVBL k=%0d", k),  32'(bus_b.LVBL), (ev >= 7) ? 0 : 1);
            chk($sformatf("b_frame VS k=%0d", k),    32'(bus_b.VS), (ev == 7) ? 1 : 0);
        end
        chk("b_frame vinit pulses", 32'(vinit_cnt), 1);
        chk("b_frame end H", 32'(bus_b.H), 0);
        chk("b_frame end V", 32'(bus_b.V), 0);
        $display("txn frame: 160 pxl_cen H=%0d V=%0d vinit_pulses=%0d", bus_b.H, bus_b.V, vinit_cnt);

`ifdef JTFRAME_VTIMER_FRAMECNT_EN
        chk("b_frame_cnt after 1", 32'(bus_b.frame_cnt), 1);
        for (int k = 0; k < 255 * 160; k++) tick(1'b1);
        chk("b_frame_cnt after 256", 32'(bus_b.frame_cnt), 0);
        chk("b_frame_cnt end H", 32'(bus_b.H), 0);
        chk("b_frame_cnt end V", 32'(bus_b.V), 0);
        $display("txn frame_cnt: after 256 frames frame_cnt=%0d", bus_b.frame_cnt);
`endif

        // Reset mid-frame while every flag sits at its non-reset value.
        for (int k = 0; k < 125; k++) tick(1'b1);
        chk("b_pre_rst H", 32'(bus_b.H), 13);
        chk("b_pre_rst V", 32'(bus_b.V), 7);
        chk("b_pre_rst LHBL", 32'(bus_b.LHBL), 0);
        chk("b_pre_rst LVBL", 32'(bus_b.LVBL), 0);
        chk("b_pre_rst HS", 32'(bus_b.HS), 1);
        chk("b_pre_rst VS", 32'(bus_b.VS), 1);
        rst_b = 1'b1;
        tick(1'b1);
        chk_reset_b("b_midrst");
`ifdef JTFRAME_VTIMER_FRAMECNT_EN
        chk("b_midrst frame_cnt", 32'(bus_b.frame_cnt), 0);
`endif
        rst_b = 1'b0;
        tick(1'b1);
        chk("b_after_rst H", 32'(bus_b.H), 1);
        chk("b_after_rst V", 32'(bus_b.V), 0);
        $display("txn midframe reset: first pxl_cen H=%0d V=%0d", bus_b.H, bus_b.V);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_vtimer.md
JTFRAME_VTIMER -- requirements
Module: jtframe_vtimer

Interface
REQ-001 Reset is synchronous and active-high; the design uses one clock, clk, with reset port rst.
REQ-002 HCNT_START, 9'd0, first H count of a line.
REQ-003 HCNT_END, 9'd383, last H count of a line.
REQ-004 HB_START, 9'd255, H blanking begins after this count.
REQ-005 HB_END, 9'd383, last blanked H count.
REQ-006 HS_START, 9'd330, first H count with HS high.
REQ-007 HS_END, 9'd356, first H count with HS low again.
REQ-008 V_START, 9'd0, first line of a frame.
REQ-009 VCNT_END, 9'd262, last line of a frame.
REQ-010 VB_START, 9'd223, V blanking begins after this line.
REQ-011 VB_END, 9'd262, last blanked line.
REQ-012 VS_START, 9'd245, first line with VS high.
REQ-013 VS_END, 9'd248, first line with VS low again.
REQ-014 clk  in  1  system clock.
REQ-015 rst  in  1  synchronous active-high reset.
REQ-016 pxl_cen  in  1  pixel clock enable; all counting happens only on clk edges with pxl_cen=1.
REQ-017 H  out  9  horizontal pixel counter.
REQ-018 V  out  9  vertical line counter.
REQ-019 Hinit  out  1  high while H==HCNT_END.
REQ-020 Vinit  out  1  high while H==HCNT_END and V==VCNT_END.
REQ-021 LHBL  out  1  active-low horizontal blank.
REQ-022 LVBL  out  1  active-low vertical blank.
REQ-023 HS  out  1  active-high horizontal sync.
REQ-024 VS  out  1  active-high vertical sync.

Function
REQ-025 On each pxl_cen: H==HCNT_END -> H<=HCNT_START, else H<=H+1; 9-bit unsigned.
REQ-026 On pxl_cen with H==HCNT_END: V==VCNT_END -> V<=V_START, else V<=V+1; V is otherwise held.
REQ-027 LHBL, LVBL, HS, VS are registered and update on the same pxl_cen edge as H/V, reflecting the new counter values (zero extra latency relative to H/V).
REQ-028 LHBL=0 exactly while HB_START < H <= HB_END, else 1.
REQ-029 LVBL=0 exactly while VB_START < V <= VB_END, else 1; it changes only at line wrap.
REQ-030 HS=1 exactly while HS_START <= H < HS_END.
REQ-031 VS=1 exactly while VS_START <= V < VS_END; it changes only at line wrap.
REQ-032 Hinit and Vinit are combinational decodes of H/V and last exactly one pixel period per line or frame.
REQ-033 pxl_cen=0 freezes all outputs; back-to-back pxl_cen advances one count per clk.

Reset
REQ-034 rst=1 on a clk edge forces H=HCNT_START, V=V_START, LHBL=1, LVBL=1, HS=0, VS=0, regardless of pxl_cen.
REQ-035 Reset mid-line or mid-frame restarts timing from the first pixel; the first pxl_cen after release gives H=HCNT_START+1.

Configuration
REQ-036 With macro JTFRAME_VTIMER_FRAMECNT_EN defined, an extra output frame_cnt [7:0] exists, resets to 0, and increments (wrapping 255->0) on each pxl_cen where Vinit=1.
REQ-037 Without JTFRAME_VTIMER_FRAMECNT_EN, the port and its logic are absent, and all other behaviour is identical.

Verification
REQ-038 Reset, then 384 pxl_cen -> H runs 0..383 then 0, Hinit high only at H=383, V goes 0->1.
REQ-039 HB_START=319: LHBL=1 for H=0..319 and LHBL=0 for H=320..383, giving 320 visible pixels per line.
REQ-040 VB_START=239: LVBL=0 for V=240..262 and 1 for V=0..239; one full frame is 384*263=100992 pxl_cen, after which V=0, H=0, and Vinit has pulsed once.
REQ-041 HS high for H=330..355; VS high for V=245..247; both low elsewhere.
REQ-042 pxl_cen held low for 50 clks mid-line -> H/V and all flags unchanged; asserting rst at H=200, V=100 -> next edge gives H=0, V=0, LHBL=LVBL=1, HS=VS=0.
REQ-043 With JTFRAME_VTIMER_FRAMECNT_EN, 256 frames -> frame_cnt wraps to 0.
